// File: rtl/wm1200_bus_pkg.sv
// Shared types and helpers for the WM1200 68020-style bus master: FSM states,
// SIZE encodings, DSACK port decode and the byte-lane routing/extract functions.
package wm1200_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_LATCH,
    ST_RELEASE,
    ST_DONE
  } state_e;

  localparam logic [1:0] SIZE_LONG  = 2'b00;
  localparam logic [1:0] SIZE_BYTE  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_3BYTE = 2'b11;

  typedef enum logic [1:0] {
    PORT_32,
    PORT_16,
    PORT_8,
    PORT_NONE
  } port_e;

  function automatic logic [1:0] size_code(input logic [2:0] n);
    case (n)
      3'd1:    return SIZE_BYTE;
      3'd2:    return SIZE_WORD;
      3'd3:    return SIZE_3BYTE;
      default: return SIZE_LONG;
    endcase
  endfunction

  function automatic port_e dsack_decode(input logic [1:0] ds);
    case (ds)
      2'b00:   return PORT_32;
      2'b01:   return PORT_16;
      2'b10:   return PORT_8;
      default: return PORT_NONE;
    endcase
  endfunction

  // Bytes a port of this width takes starting at this address, capped by what is left.
  function automatic logic [2:0] accept_count(input port_e p, input logic [1:0] a10,
                                              input logic [2:0] n);
    logic [2:0] room;
    case (p)
      PORT_32: room = 3'd4 - {1'b0, a10};
      PORT_16: room = 3'd2 - {2'b00, a10[0]};
      default: room = 3'd1;
    endcase
    return (n < room) ? n : room;
  endfunction

  // Lane 0 is D31:24.
  function automatic logic [7:0] byte_extract(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // r holds the remaining operand bytes left-justified (R0 in r[31:24]).
  function automatic logic [31:0] lane_route(input logic [31:0] r, input logic [1:0] a10,
                                             input logic [2:0] n);
    logic [31:0] o;
    o = '0;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(a10) && (j - int'(a10)) < int'(n))
        o[31-8*j -: 8] = byte_extract(r, 2'(j - int'(a10)));
    end
    o[31:24] = r[31:24];
    // Narrow ports only see the upper lanes, so mirror the bytes they will pick up.
    if (a10[0])
      o[23:16] = r[31:24];
    else if (a10 == 2'd2 && n >= 3'd2)
      o[23:16] = r[23:16];
    return o;
  endfunction

  function automatic logic [31:0] shift_in(input logic [31:0] acc, input logic [31:0] din,
                                           input port_e p, input logic [1:0] a10,
                                           input logic [2:0] k);
    logic [1:0]  s;
    logic [31:0] r;
    case (p)
      PORT_32: s = a10;
      PORT_16: s = {1'b0, a10[0]};
      default: s = 2'd0;
    endcase
    r = acc;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(k))
        r = {r[23:0], byte_extract(din, s + 2'(i))};
    end
    return r;
  endfunction

endpackage

// File: rtl/wm1200_sync.sv
// Multi-flop synchroniser for the asynchronous active-low bus terminations;
// resets to all ones so terminations read as negated.
module wm1200_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '1;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/m68k_bus_master.sv
// 68EC020-style asynchronous bus-cycle engine: splits one operand into bus cycles
// using DSACK dynamic sizing, with bus-error and timeout termination.
module m68k_bus_master
  import wm1200_bus_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              cpuclk_a,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rw,
  input  logic [2:0]        req_bytes,
  input  logic [2:0]        req_fc,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] A,
  output logic [2:0]        fc,
  output logic [1:0]        size,
  output logic              r_w,
  output logic              as_n,
  output logic              ds_n,
  input  logic [1:0]        dsack,
  input  logic              berr_n,
  output logic [31:0]       data_out,
  output logic              data_dir,
  input  logic [31:0]       data_in,
  output logic              d_buff_dir,
  output logic              d_buff_oe_n,
  output logic              a_buff_dir,
  output logic              a_buff_oe_n
);

  localparam logic [1:0]  SETUP_LAST = 2'(SETUP_CYC - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 1);

  state_e            st;
  logic [1:0]        set_cnt;
  logic [15:0]       tmo;
  logic [ADDR_W-1:0] a;
  logic [2:0]        n;
  logic              rw;
  logic [31:0]       wbuf;
  logic [31:0]       racc;
  logic              err;
  port_e             port_q;
  logic [1:0]        ds;
  logic              berr_s;

  logic [2:0]  lj_sh;
  logic [31:0] req_wjust;
  logic [2:0]  k_now;
  logic        tmo_hit;
  logic        go_done;
  logic        tmo_err;

  wm1200_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_dsack (
    .clk (cpuclk_a),
    .rst (rst),
    .d   (dsack),
    .q   (ds)
  );

  wm1200_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_berr (
    .clk (cpuclk_a),
    .rst (rst),
    .d   (berr_n),
    .q   (berr_s)
  );

  assign a_buff_dir = 1'b1;

  always_comb begin
    lj_sh     = 3'd4 - req_bytes;
    req_wjust = req_wdata << {lj_sh, 3'b000};
    k_now     = accept_count(port_q, a[1:0], n);
    tmo_hit   = (tmo == TMO_LAST);
    go_done   = 1'b0;
    tmo_err   = 1'b0;
    if (st == ST_WAIT && berr_s && ds == 2'b11 && tmo_hit) begin
      go_done = 1'b1;
      tmo_err = 1'b1;
    end
    // The timeout keeps running while waiting for DSACK to negate.
    if (st == ST_RELEASE) begin
      if (ds == 2'b11) begin
        go_done = (n == 3'd0) || err;
      end else if (tmo_hit) begin
        go_done = 1'b1;
        tmo_err = 1'b1;
      end
    end
  end

  always_ff @(posedge cpuclk_a) begin
    if (rst) begin
      st          <= ST_IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      as_n        <= 1'b1;
      ds_n        <= 1'b1;
      r_w         <= 1'b1;
      data_dir    <= 1'b1;
      a_buff_oe_n <= 1'b1;
      d_buff_oe_n <= 1'b1;
      d_buff_dir  <= 1'b0;
      A           <= '0;
      fc          <= '0;
      size        <= '0;
      data_out    <= '0;
      set_cnt     <= '0;
      tmo         <= '0;
      err         <= 1'b0;
      port_q      <= PORT_NONE;
    end else begin
      case (st)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            a           <= req_addr;
            n           <= req_bytes;
            rw          <= req_rw;
            wbuf        <= req_wjust;
            racc        <= '0;
            err         <= 1'b0;
            set_cnt     <= '0;
            A           <= req_addr;
            fc          <= req_fc;
            r_w         <= req_rw;
            size        <= size_code(req_bytes);
            a_buff_oe_n <= 1'b0;
            d_buff_oe_n <= 1'b0;
            d_buff_dir  <= ~req_rw;
            data_dir    <= req_rw;
            data_out    <= req_rw ? '0 : lane_route(req_wjust, req_addr[1:0], req_bytes);
            st          <= ST_SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (set_cnt == SETUP_LAST) begin
            as_n <= 1'b0;
            ds_n <= ~rw;
            st   <= ST_STROBE;
          end else begin
            set_cnt <= set_cnt + 2'd1;
          end
        end
        ST_STROBE: begin
          ds_n <= 1'b0;
          tmo  <= '0;
          st   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!berr_s) begin
            err  <= 1'b1;
            as_n <= 1'b1;
            ds_n <= 1'b1;
            st   <= ST_RELEASE;
          end else if (ds != 2'b11) begin
            port_q <= dsack_decode(ds);
            st     <= ST_LATCH;
          end else if (!tmo_hit) begin
            tmo <= tmo + 16'd1;
          end
        end
        ST_LATCH: begin
          if (rw) racc <= shift_in(racc, data_in, port_q, a[1:0], k_now);
          a    <= a + ADDR_W'(k_now);
          n    <= n - k_now;
          wbuf <= wbuf << {k_now, 3'b000};
          as_n <= 1'b1;
          ds_n <= 1'b1;
          st   <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (ds == 2'b11) begin
            if (!go_done) begin
              set_cnt  <= '0;
              A        <= a;
              size     <= size_code(n);
              data_out <= rw ? '0 : lane_route(wbuf, a[1:0], n);
              st       <= ST_SETUP;
            end
          end else if (!tmo_hit) begin
            tmo <= tmo + 16'd1;
          end
        end
        ST_DONE: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          st        <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase

      if (go_done) begin
        st          <= ST_DONE;
        rsp_valid   <= 1'b1;
        rsp_err     <= err | tmo_err;
        rsp_rdata   <= racc;
        as_n        <= 1'b1;
        ds_n        <= 1'b1;
        r_w         <= 1'b1;
        data_dir    <= 1'b1;
        a_buff_oe_n <= 1'b1;
        d_buff_oe_n <= 1'b1;
        d_buff_dir  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master with a simple asynchronous slave model
// that asserts DSACK/BERR while as_n is low.
module tb_m68k_bus_master;

  logic        cpuclk_a = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic        req_rw = 1'b1;
  logic [2:0]  req_bytes = 3'd4;
  logic [2:0]  req_fc = 3'd0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [23:0] A;
  logic [2:0]  fc;
  logic [1:0]  size;
  logic        r_w, as_n, ds_n;
  logic [1:0]  dsack;
  logic        berr_n;
  logic [31:0] data_out;
  logic        data_dir;
  logic [31:0] data_in;
  logic        d_buff_dir, d_buff_oe_n, a_buff_dir, a_buff_oe_n;

  int n_pass = 0;
  int n_chk  = 0;

  logic [1:0]  slave_ds = 2'b11;
  logic        slave_berr = 1'b0;
  logic [31:0] rd_tab [4];
  int          base = 0;

  int          bus_cnt = 0;
  logic        as_prev = 1'b1;
  int          age = 0;
  logic [23:0] log_a    [32];
  logic [1:0]  log_size [32];
  logic [31:0] log_dout [32];
  logic [2:0]  log_fc   [32];
  logic        log_ds0  [32];
  logic        log_ds1  [32];

  m68k_bus_master #(
    .ADDR_W(24), .SYNC_STAGES(2), .SETUP_CYC(1), .TIMEOUT_CYC(20)
  ) dut (
    .cpuclk_a(cpuclk_a), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_bytes(req_bytes), .req_fc(req_fc), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A(A), .fc(fc), .size(size), .r_w(r_w), .as_n(as_n), .ds_n(ds_n),
    .dsack(dsack), .berr_n(berr_n),
    .data_out(data_out), .data_dir(data_dir), .data_in(data_in),
    .d_buff_dir(d_buff_dir), .d_buff_oe_n(d_buff_oe_n),
    .a_buff_dir(a_buff_dir), .a_buff_oe_n(a_buff_oe_n)
  );

  always #5 cpuclk_a = ~cpuclk_a;

  always_comb begin
    int idx;
    dsack   = as_n ? 2'b11 : slave_ds;
    berr_n  = as_n ? 1'b1 : ~slave_berr;
    idx     = bus_cnt - base - 1;
    data_in = (idx >= 0 && idx < 4) ? rd_tab[idx] : 32'h0;
  end

  always @(negedge cpuclk_a) begin
    if (!as_n && as_prev && bus_cnt < 32) begin
      log_a[bus_cnt]    = A;
      log_size[bus_cnt] = size;
      log_dout[bus_cnt] = data_out;
      log_fc[bus_cnt]   = fc;
      log_ds0[bus_cnt]  = ds_n;
      bus_cnt = bus_cnt + 1;
      age = 0;
    end else if (!as_n && bus_cnt > 0) begin
      if (age == 0) log_ds1[bus_cnt-1] = ds_n;
      age = age + 1;
    end
    as_prev = as_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_req(input logic [23:0] addr, input logic rw, input logic [2:0] nb,
                        input logic [2:0] f, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int  i;
    bit  got;
    lat = 0; rd = 'x; er = 1'bx; got = 0;
    base = bus_cnt;
    i = 0;
    @(negedge cpuclk_a);
    while (!req_ready && i < 50) begin @(negedge cpuclk_a); i++; end
    req_valid = 1'b1; req_addr = addr; req_rw = rw; req_bytes = nb;
    req_fc = f; req_wdata = wd;
    @(posedge cpuclk_a);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 500; c++) begin
      @(negedge cpuclk_a);
      if (rsp_valid) begin
        got = 1; lat = c; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    check("rsp_arrived", 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    rd_tab[0] = '0; rd_tab[1] = '0; rd_tab[2] = '0; rd_tab[3] = '0;
    repeat (2) @(posedge cpuclk_a);
    @(negedge cpuclk_a);
    check("rst_as_n",     32'(as_n), 32'd1);
    check("rst_ds_n",     32'(ds_n), 32'd1);
    check("rst_r_w",      32'(r_w), 32'd1);
    check("rst_data_dir", 32'(data_dir), 32'd1);
    check("rst_oe",       {30'd0, a_buff_oe_n, d_buff_oe_n}, 32'd3);
    check("rst_bdir",     {30'd0, a_buff_dir, d_buff_dir}, 32'd2);
    check("rst_A",        32'(A), 32'd0);
    check("rst_fc_size",  {27'd0, fc, size}, 32'd0);
    check("rst_dout",     data_out, 32'd0);
    check("rst_ready",    32'(req_ready), 32'd0);
    check("rst_rsp",      {rsp_rdata[30:0], rsp_valid} | 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge cpuclk_a);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Long read from a 32-bit port.
    slave_ds = 2'b00; slave_berr = 1'b0; rd_tab[0] = 32'hDEADBEEF;
    do_req(24'h000100, 1'b1, 3'd4, 3'd5, 32'h0, rd, er, lat);
    check("lr_rdata", rd, 32'hDEADBEEF);
    check("lr_err",   32'(er), 32'd0);
    check("lr_cycles", 32'(bus_cnt - base), 32'd1);
    check("lr_A",     32'(log_a[base]), 32'h100);
    check("lr_size",  32'(log_size[base]), 32'd0);
    check("lr_fc",    32'(log_fc[base]), 32'd5);
    check("lr_ds_with_as", 32'(log_ds0[base]), 32'd0);
    check("lr_latency", 32'(lat), 32'd9);
    check("lr_ready_done", 32'(req_ready), 32'd0);
    @(negedge cpuclk_a);
    check("lr_ready_after", 32'(req_ready), 32'd1);

    // Long write split over a 16-bit port.
    slave_ds = 2'b01;
    do_req(24'h000102, 1'b0, 3'd4, 3'd1, 32'h11223344, rd, er, lat);
    check("lw_err",    32'(er), 32'd0);
    check("lw_cycles", 32'(bus_cnt - base), 32'd2);
    check("lw_A0",     32'(log_a[base]), 32'h102);
    check("lw_size0",  32'(log_size[base]), 32'd0);
    check("lw_d0",     32'(log_dout[base][31:16]), 32'h1122);
    check("lw_A1",     32'(log_a[base+1]), 32'h104);
    check("lw_size1",  32'(log_size[base+1]), 32'd2);
    check("lw_d1",     32'(log_dout[base+1][31:16]), 32'h3344);

    // Word read at an odd address from an 8-bit port.
    slave_ds = 2'b10; rd_tab[0] = 32'hAB000000; rd_tab[1] = 32'hCD000000;
    do_req(24'h000003, 1'b1, 3'd2, 3'd1, 32'h0, rd, er, lat);
    check("wr8_rdata",  rd, 32'h0000ABCD);
    check("wr8_cycles", 32'(bus_cnt - base), 32'd2);
    check("wr8_A0",     32'(log_a[base]), 32'h3);
    check("wr8_size0",  32'(log_size[base]), 32'd2);
    check("wr8_A1",     32'(log_a[base+1]), 32'h4);
    check("wr8_size1",  32'(log_size[base+1]), 32'd1);

    // Byte write at offset 1: duplicated onto D31:24, ds_n trails as_n.
    slave_ds = 2'b00;
    do_req(24'h000001, 1'b0, 3'd1, 3'd1, 32'h0000005A, rd, er, lat);
    check("bw_cycles", 32'(bus_cnt - base), 32'd1);
    check("bw_dout",   log_dout[base], 32'h5A5A0000);
    check("bw_size",   32'(log_size[base]), 32'd1);
    check("bw_ds0",    32'(log_ds0[base]), 32'd1);
    check("bw_ds1",    32'(log_ds1[base]), 32'd0);

    // Bus error together with a 32-bit termination on a split-capable request.
    slave_ds = 2'b00; slave_berr = 1'b1;
    do_req(24'h000203, 1'b1, 3'd4, 3'd1, 32'h0, rd, er, lat);
    check("berr_err",    32'(er), 32'd1);
    check("berr_cycles", 32'(bus_cnt - base), 32'd1);
    check("berr_strobe", {30'd0, as_n, ds_n}, 32'd3);
    slave_berr = 1'b0;

    // No termination at all: timeout after 20 WAIT cycles.
    slave_ds = 2'b11;
    do_req(24'h000400, 1'b1, 3'd4, 3'd1, 32'h0, rd, er, lat);
    check("tmo_err",     32'(er), 32'd1);
    check("tmo_latency", 32'(lat), 32'd23);
    check("tmo_strobe",  {30'd0, as_n, ds_n}, 32'd3);

    // Reset while a write sits in WAIT.
    @(negedge cpuclk_a);
    req_valid = 1'b1; req_addr = 24'h000300; req_rw = 1'b0; req_bytes = 3'd4;
    req_wdata = 32'hCAFEF00D;
    @(posedge cpuclk_a);
    #1 req_valid = 1'b0;
    repeat (6) @(negedge cpuclk_a);
    check("mid_as_n_low",  32'(as_n), 32'd0);
    check("mid_dir_drive", 32'(data_dir), 32'd0);
    rst = 1'b1;
    @(posedge cpuclk_a);
    #1;
    check("mid_rst_as_n", 32'(as_n), 32'd1);
    check("mid_rst_dir",  32'(data_dir), 32'd1);
    check("mid_rst_ds_n", 32'(ds_n), 32'd1);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge cpuclk_a);
      if (rsp_valid) seen++;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);
    check("mid_ready",  32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m68k_bus_master.md
# m68k_bus_master

Parametrised 68EC020-style asynchronous bus-cycle engine for the WM1200 FPGA. It turns single-operand requests from internal logic into MC68020 bus cycles, driving address, strobes and the tristated data bus together with the data/address buffer controls. It splits operands across 8-, 16- and 32-bit ports using DSACK dynamic bus sizing, terminates on bus error or timeout, and returns read data plus a status response.

## Interface
- ADDR_W, 24: external address width
- SYNC_STAGES, 2: synchroniser depth for dsack/berr_n, 2..4
- SETUP_CYC, 1: cycles of address/fc/size setup before as_n asserts, 1..3
- TIMEOUT_CYC, 255: cycles in WAIT without termination before a timeout error, 1..65535

Ports:
- cpuclk_a  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_addr  in  ADDR_W  byte address of the first operand byte
- req_rw  in  1  1 = read, 0 = write
- req_bytes  in  3  operand length, 1..4
- req_fc  in  3  function code
- req_wdata  in  32  operand, MSB-first (R0 = bits 31:24 when length is 4)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read operand, right-justified
- rsp_err  out  1  bus error or timeout
- A, fc, size, r_w, as_n, ds_n  out  ADDR_W, 3, 2, 1, 1, 1  68020 bus outputs
- dsack, berr_n  in  2, 1  raw asynchronous terminations, active low
- data_out, data_dir  out  32, 1  data bus drive value; data_dir = 1 releases D (hi-Z)
- data_in  in  32  D sampled
- d_buff_dir, d_buff_oe_n, a_buff_dir, a_buff_oe_n  out  1 each  buffer control

## Operation
- States: IDLE, SETUP, STROBE, WAIT, LATCH, RELEASE, DONE.
- IDLE: req_ready = 1. A request is accepted when req_valid and req_ready are both high. The block latches the request and sets remaining count n = req_bytes and current address a = req_addr.
- SETUP (SETUP_CYC cycles): drive A = a, fc, r_w = req_rw and size = n[1:0] (n = 4 gives 2'b00). Assert a_buff_oe_n = 0 and d_buff_oe_n = 0.
  - Writes: data_dir = 0, and data_out is set by lane routing.
- STROBE: as_n = 0. For reads, ds_n = 0 in the same cycle; for writes, ds_n = 0 one cycle later.
- WAIT: uses the synchronised dsack value ds.
  - ds = 2'b00 selects a 32-bit port; 2'b01 a 16-bit port; 2'b10 an 8-bit port; 2'b11 keeps waiting.
  - If synchronised berr_n = 0, the cycle ends with an error. This takes priority over dsack in the same cycle.
- LATCH: for reads, capture the accepted bytes from the port lanes (D31:24 first) into the rsp_rdata shifter.
  - Accepted count k = min(n, P − (a mod P)), where P is the port width in bytes.
  - Update a += k and n −= k.
- RELEASE: as_n = ds_n = 1. Write data is held this cycle. Wait for ds = 2'b11, then go to SETUP if n > 0 and no error, otherwise go to DONE.
- DONE: rsp_valid = 1 for one cycle, then return to IDLE. Release the buffers (oe_n = 1) and set data_dir = 1.
- Write lane routing for remaining bytes R0..Rn−1, where lane j = 0 is D31:24:
  - Lanes j ≥ a[1:0] carry R[j − a[1:0]].
  - D31:24 always carries R0.
  - When a[0] = 1, D23:16 also carries R0.
  - Unfilled lanes are 0.
- Buffer controls: d_buff_dir = ~r_w while the bus is owned (1 = FPGA→bus). a_buff_dir = 1 constant.
- Timeout: a counter of TIMEOUT_CYC cycles spans both WAIT and the RELEASE dsack-negate wait. On expiry, rsp_err = 1 and the block goes to DONE with strobes negated.

## Timing
- Reset values: as_n = ds_n = r_w = data_dir = a_buff_oe_n = d_buff_oe_n = 1; a_buff_dir = 1; d_buff_dir = 0; A = fc = size = 0; data_out = 0; req_ready = 0 in the reset cycle and 1 from the next cycle; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; state = IDLE.
- Reset mid-cycle: strobes negate on the very next edge. No rsp_valid is produced.
- Minimum 32-bit read, with dsack already low: accept at cycle 0; SETUP 1; STROBE 2; WAIT sees ds at cycle 2 + SYNC_STAGES; LATCH; RELEASE; DONE.
- Split cycles re-enter SETUP with the new address and size and with as_n negated for at least one cycle.
- Each response has req_ready = 0 from accept until the cycle after DONE.

## Structure
- Package wm1200_bus_pkg holds:
  - state enum
  - size encoding constants
  - port-width enum and dsack decode function
  - lane-routing function and byte-extract function
- Sub-module wm1200_sync: SYNC_STAGES-deep flop synchroniser, instantiated for dsack[1:0] and berr_n. Reset value is 1s (negated).

## Test plan
- Long read at 0x000100 with a 32-bit port returning 0xDEADBEEF → one bus cycle, size = 00, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Long write of 0x11223344 at 0x000102 to a 16-bit port → two cycles: A = 0x102 size = 00 (D31:16 = 0x1122), then A = 0x104 size = 10 (D31:16 = 0x3344).
- Word read at 0x000003 from an 8-bit port returning 0xAB then 0xCD → two cycles at A = 3 and A = 4, rsp_rdata = 0x0000ABCD.
- Byte write of 0x5A at 0x000001 to a 32-bit port → D23:16 = 0x5A and D31:24 = 0x5A, ds_n falls one cycle after as_n.
- berr_n low together with dsack = 00 → rsp_err = 1, no further split, strobes negated.
- No termination → rsp_err = 1 after TIMEOUT_CYC cycles in WAIT. A separate case asserts rst during WAIT → as_n = 1 and data_dir = 1 on the next edge, with no rsp_valid.
